// File: rtl/fp_addsub_pipelined.sv
// ---------------------------------------------------------------------------
// fp_addsub_pipelined
//   Parametrised IEEE-754 style add/subtract unit with a 5-stage pipeline.
//   Subnormal operands and results are flushed to signed zero, rounding is
//   round-to-nearest-even, and NaN/Inf operands are resolved at entry.
//
// Ports
//   clk, reset_n            clock (rising edge), async active-low reset
//   in_valid / in_ready     operand handshake (in_ready is combinational)
//   a, b                    operands {sign, exp, frac}
//   op_sub                  0: a+b, 1: a-b
//   in_tag                  opaque tag, returned with the result
//   out_valid / out_ready   result handshake
//   c                       result {sign, exp, frac}
//   out_tag                 tag of the result
//   flags                   {invalid, overflow, underflow, inexact}
// ---------------------------------------------------------------------------
module fp_addsub_pipelined #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int TAG_W  = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+FRAC_W:0]   a,
  input  logic [EXP_W+FRAC_W:0]   b,
  input  logic                    op_sub,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   c,
  output logic [TAG_W-1:0]        out_tag,
  output logic [3:0]              flags
);

  localparam int W   = 1 + EXP_W + FRAC_W;
  localparam int M   = FRAC_W + 1;            // mantissa incl. hidden bit
  localparam int X   = FRAC_W + 4;            // mantissa plus guard/round/sticky
  localparam int LZW = $clog2(X + 1);
  localparam int SW  = TAG_W + 1 + W + 4;     // {tag, special, special value, special flags}
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(FRAC_W-1){1'b0}}};

  // Leading-zero count; returns X for an all-zero vector.
  function automatic logic [LZW-1:0] lzc(input logic [X-1:0] v);
    logic [LZW-1:0] n;
    logic           found;
    n     = {LZW{1'b0}};
    found = 1'b0;
    for (int i = X - 1; i >= 0; i--) begin
      n     = (found || v[i]) ? n : n + LZW'(1);
      found = found | v[i];
    end
    return n;
  endfunction

  // Flow control: a stage loads when the stage after it is empty or moving.
  logic en1_s, en2_s, en3_s, en4_s, en5_s;
  logic v1_r, v2_r, v3_r, v4_r, out_valid_r;

  assign en5_s    = !out_valid_r || out_ready;
  assign en4_s    = !v4_r || en5_s;
  assign en3_s    = !v3_r || en4_s;
  assign en2_s    = !v2_r || en3_s;
  assign en1_s    = !v1_r || en2_s;
  assign in_ready = en1_s;

  // ---------------- S1: unpack, classify, swap ----------------
  logic             sa_s, sb_s, a_nan_s, b_nan_s, a_inf_s, b_inf_s, swap_s;
  logic [EXP_W-1:0] ea_s, eb_s;
  logic [M-1:0]     ma_s, mb_s;
  logic             spec_s;
  logic [W-1:0]     sval_s;
  logic [3:0]       sflg_s;

  assign sa_s    = a[W-1];
  assign sb_s    = b[W-1] ^ op_sub;
  assign ea_s    = a[W-2:FRAC_W];
  assign eb_s    = b[W-2:FRAC_W];
  assign ma_s    = (ea_s == {EXP_W{1'b0}}) ? {M{1'b0}} : {1'b1, a[FRAC_W-1:0]};
  assign mb_s    = (eb_s == {EXP_W{1'b0}}) ? {M{1'b0}} : {1'b1, b[FRAC_W-1:0]};
  assign a_nan_s = (ea_s == EXP_ONES) && (a[FRAC_W-1:0] != {FRAC_W{1'b0}});
  assign b_nan_s = (eb_s == EXP_ONES) && (b[FRAC_W-1:0] != {FRAC_W{1'b0}});
  assign a_inf_s = (ea_s == EXP_ONES) && (a[FRAC_W-1:0] == {FRAC_W{1'b0}});
  assign b_inf_s = (eb_s == EXP_ONES) && (b[FRAC_W-1:0] == {FRAC_W{1'b0}});
  assign swap_s  = {eb_s, mb_s} > {ea_s, ma_s};

  // Resolve NaN/Inf operands at entry; later stages only carry the answer.
  always_comb begin
    spec_s = 1'b0;
    sval_s = {W{1'b0}};
    sflg_s = 4'b0000;
    if (a_nan_s || b_nan_s) begin
      spec_s = 1'b1;
      sval_s = QNAN;
    end else if (a_inf_s && b_inf_s && (sa_s != sb_s)) begin
      spec_s = 1'b1;
      sval_s = QNAN;
      sflg_s = 4'b1000;
    end else if (a_inf_s) begin
      spec_s = 1'b1;
      sval_s = {sa_s, EXP_ONES, {FRAC_W{1'b0}}};
    end else if (b_inf_s) begin
      spec_s = 1'b1;
      sval_s = {sb_s, EXP_ONES, {FRAC_W{1'b0}}};
    end else begin
      spec_s = 1'b0;
    end
  end

  logic [SW-1:0]    side1_r, side2_r, side3_r, side4_r;
  logic             sign1_r, sub1_r;
  logic [EXP_W-1:0] exp1_r, d1_r;
  logic [M-1:0]     ml1_r, ms1_r;

  // Stage 1 register: larger-magnitude operand becomes L.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_r <= 1'b0; side1_r <= '0; sign1_r <= 1'b0; sub1_r <= 1'b0;
      exp1_r <= '0; d1_r <= '0; ml1_r <= '0; ms1_r <= '0;
    end else if (en1_s) begin
      v1_r <= in_valid;
      if (in_valid) begin
        side1_r <= {in_tag, spec_s, sval_s, sflg_s};
        sign1_r <= swap_s ? sb_s : sa_s;
        sub1_r  <= sa_s ^ sb_s;
        exp1_r  <= swap_s ? eb_s : ea_s;
        d1_r    <= swap_s ? (eb_s - ea_s) : (ea_s - eb_s);
        ml1_r   <= swap_s ? mb_s : ma_s;
        ms1_r   <= swap_s ? ma_s : mb_s;
      end
    end
  end

  // ---------------- S2: align S to L ----------------
  logic [X-1:0] ext2_s, sh2_s, al2_s;
  logic         lost2_s, big2_s;

  assign ext2_s  = {ms1_r, 3'b000};
  assign sh2_s   = ext2_s >> d1_r;
  assign lost2_s = |(ext2_s & ~({X{1'b1}} << d1_r));
  assign big2_s  = 32'(d1_r) >= 32'(X - 1);
  // Beyond FRAC_W+3 the whole of S collapses into the sticky bit.
  assign al2_s   = big2_s ? {{(X-1){1'b0}}, |ms1_r} : {sh2_s[X-1:1], sh2_s[0] | lost2_s};

  logic             sign2_r, sub2_r;
  logic [EXP_W-1:0] exp2_r;
  logic [M-1:0]     ml2_r;
  logic [X-1:0]     al2_r;

  // Stage 2 register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v2_r <= 1'b0; side2_r <= '0; sign2_r <= 1'b0; sub2_r <= 1'b0;
      exp2_r <= '0; ml2_r <= '0; al2_r <= '0;
    end else if (en2_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        side2_r <= side1_r; sign2_r <= sign1_r; sub2_r <= sub1_r;
        exp2_r  <= exp1_r;  ml2_r   <= ml1_r;   al2_r  <= al2_s;
      end
    end
  end

  // ---------------- S3: add / subtract (never negative since |L|>=|S|) ----------------
  logic             sign3_r, sub3_r;
  logic [EXP_W-1:0] exp3_r;
  logic [X:0]       sum3_r;

  // Stage 3 register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v3_r <= 1'b0; side3_r <= '0; sign3_r <= 1'b0; sub3_r <= 1'b0;
      exp3_r <= '0; sum3_r <= '0;
    end else if (en3_s) begin
      v3_r <= v2_r;
      if (v2_r) begin
        side3_r <= side2_r; sign3_r <= sign2_r; sub3_r <= sub2_r; exp3_r <= exp2_r;
        sum3_r  <= sub2_r ? ({1'b0, ml2_r, 3'b000} - {1'b0, al2_r})
                          : ({1'b0, ml2_r, 3'b000} + {1'b0, al2_r});
      end
    end
  end

  // ---------------- S4: normalise ----------------
  logic [LZW-1:0] lz4_s;
  logic [X-1:0]   mant4_s;
  logic [EXP_W:0] exp4_s;
  logic           zero4_s, uf4_s, sign4_s;

  assign lz4_s = lzc(sum3_r[X-1:0]);

  // Carry shifts right; otherwise shift left unless the result would be subnormal.
  always_comb begin
    mant4_s = {X{1'b0}};
    exp4_s  = {(EXP_W+1){1'b0}};
    zero4_s = 1'b0;
    uf4_s   = 1'b0;
    sign4_s = sign3_r;
    if (sum3_r[X]) begin
      mant4_s = {sum3_r[X:2], |sum3_r[1:0]};
      exp4_s  = {1'b0, exp3_r} + {{EXP_W{1'b0}}, 1'b1};
    end else if (sum3_r[X-1:0] == {X{1'b0}}) begin
      // Exact cancellation gives +0; only -0 + -0 keeps the sign.
      zero4_s = 1'b1;
      sign4_s = sub3_r ? 1'b0 : sign3_r;
    end else if (32'(lz4_s) >= 32'(exp3_r)) begin
      zero4_s = 1'b1;
      uf4_s   = 1'b1;
    end else begin
      mant4_s = sum3_r[X-1:0] << lz4_s;
      exp4_s  = {1'b0, exp3_r} - (EXP_W+1)'(lz4_s);
    end
  end

  logic [X-1:0]   mant4_r;
  logic [EXP_W:0] exp4_r;
  logic           zero4_r, uf4_r, sign4_r;

  // Stage 4 register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v4_r <= 1'b0; side4_r <= '0; mant4_r <= '0; exp4_r <= '0;
      zero4_r <= 1'b0; uf4_r <= 1'b0; sign4_r <= 1'b0;
    end else if (en4_s) begin
      v4_r <= v3_r;
      if (v3_r) begin
        side4_r <= side3_r; mant4_r <= mant4_s; exp4_r <= exp4_s;
        zero4_r <= zero4_s; uf4_r   <= uf4_s;   sign4_r <= sign4_s;
      end
    end
  end

  // ---------------- S5: round to nearest even, pack ----------------
  logic [M-1:0]      m5_s;
  logic              g5_s, r5_s, st5_s, up5_s;
  logic [M:0]        rnd5_s;
  logic [EXP_W:0]    exp5_s;
  logic [FRAC_W-1:0] frac5_s;
  logic [W-1:0]      res5_s;
  logic [3:0]        flg5_s;

  assign m5_s    = mant4_r[X-1:3];
  assign g5_s    = mant4_r[2];
  assign r5_s    = mant4_r[1];
  assign st5_s   = mant4_r[0];
  assign up5_s   = g5_s && (r5_s || st5_s || m5_s[0]);
  assign rnd5_s  = {1'b0, m5_s} + {{M{1'b0}}, up5_s};
  assign exp5_s  = exp4_r + {{EXP_W{1'b0}}, rnd5_s[M]};
  assign frac5_s = rnd5_s[M] ? rnd5_s[FRAC_W:1] : rnd5_s[FRAC_W-1:0];

  // Final result select: forced special, zero, overflow to Inf, or normal.
  always_comb begin
    res5_s = {W{1'b0}};
    flg5_s = 4'b0000;
    if (side4_r[W+4]) begin
      res5_s = side4_r[W+3:4];
      flg5_s = side4_r[3:0];
    end else if (zero4_r) begin
      res5_s = {sign4_r, {(W-1){1'b0}}};
      flg5_s = {2'b00, uf4_r, 1'b0};
    end else if (exp5_s >= {1'b0, EXP_ONES}) begin
      res5_s = {sign4_r, EXP_ONES, {FRAC_W{1'b0}}};
      flg5_s = 4'b0101;
    end else begin
      res5_s = {sign4_r, exp5_s[EXP_W-1:0], frac5_s};
      flg5_s = {3'b000, g5_s | r5_s | st5_s};
    end
  end

  logic [W-1:0]     c_r;
  logic [TAG_W-1:0] out_tag_r;
  logic [3:0]       flags_r;

  // Output register; holds while out_valid && !out_ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r <= 1'b0; c_r <= '0; out_tag_r <= '0; flags_r <= 4'b0000;
    end else if (en5_s) begin
      out_valid_r <= v4_r;
      if (v4_r) begin
        c_r       <= res5_s;
        out_tag_r <= side4_r[SW-1 -: TAG_W];
        flags_r   <= flg5_s;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign c         = c_r;
  assign out_tag   = out_tag_r;
  assign flags     = flags_r;

endmodule

// File: tb/tb_fp_addsub_pipelined.sv
module tb_fp_addsub_pipelined;

  logic        clk = 1'b0;
  logic        reset_n;
  // single-precision instance
  logic        in_valid, in_ready, op_sub, out_valid, out_ready;
  logic [31:0] a, b, c;
  logic [3:0]  in_tag, out_tag, flags;
  // half-precision instance
  logic        h_in_valid, h_in_ready, h_op_sub, h_out_valid, h_out_ready;
  logic [15:0] h_a, h_b, h_c;
  logic [3:0]  h_in_tag, h_out_tag, h_flags;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fp_addsub_pipelined #(.EXP_W(8), .FRAC_W(23), .TAG_W(4)) u_sp (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op_sub(op_sub), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .c(c), .out_tag(out_tag), .flags(flags));

  fp_addsub_pipelined #(.EXP_W(5), .FRAC_W(10), .TAG_W(4)) u_hp (
    .clk(clk), .reset_n(reset_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .a(h_a), .b(h_b), .op_sub(h_op_sub), .in_tag(h_in_tag), .out_valid(h_out_valid),
    .out_ready(h_out_ready), .c(h_c), .out_tag(h_out_tag), .flags(h_flags));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] c;
    logic [3:0]  f;
  } vec_t;

  vec_t v32 [21];
  vec_t v16 [3];

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] expv);
    tests_run++;
    if (act !== expv) begin
      tests_failed++;
      $display("FAIL %s #%0d: got %h, expected %h", nm, id, act, expv);
    end
  endtask

  // Stream operand i and its doubled value (x + x raises the exponent by one).
  function automatic logic [31:0] s_in(input int i);
    logic [22:0] f;
    f = 23'(i * 32'h0001_3579);
    return {1'b0, 8'(100 + i), f};
  endfunction

  function automatic logic [31:0] s_out(input int i);
    logic [22:0] f;
    f = 23'(i * 32'h0001_3579);
    return {1'b0, 8'(101 + i), f};
  endfunction

  // One isolated operation on either instance; checks latency, result, flags, tag.
  task automatic run_op(input bit h, input logic [31:0] av, input logic [31:0] bv, input logic opv,
                        input logic [3:0] tg, input logic [31:0] ec, input logic [3:0] ef, input int id);
    int   lat;
    logic ov;
    @(negedge clk);
    if (h) begin
      h_in_valid = 1'b1; h_a = av[15:0]; h_b = bv[15:0]; h_op_sub = opv; h_in_tag = tg;
    end else begin
      in_valid = 1'b1; a = av; b = bv; op_sub = opv; in_tag = tg; out_ready = 1'b1;
    end
    #1;
    chk("in_ready", id, 32'(h ? h_in_ready : in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; h_in_valid = 1'b0;
    lat = 1;
    ov  = h ? h_out_valid : out_valid;
    while (!ov && lat < 20) begin
      @(negedge clk);
      lat++;
      ov = h ? h_out_valid : out_valid;
    end
    chk("latency", id, 32'(lat), 32'd5);
    chk("result", id, h ? {16'h0000, h_c} : c, ec);
    chk("flags", id, 32'(h ? h_flags : flags), 32'(ef));
    chk("tag", id, 32'(h ? h_out_tag : out_tag), 32'(tg));
  endtask

  initial begin
    int sent, rcvd, extra, acc, ghost, wcyc;

    v32[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000}; // 1+2
    v32[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000}; // 1-1
    v32[2]  = '{32'hBF800000, 32'h3F800000, 1'b0, 32'h00000000, 4'b0000}; // -1+1
    v32[3]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000}; // -0+-0
    v32[4]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001}; // tie to even
    v32[5]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001}; // tie, odd -> up
    v32[6]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101}; // overflow
    v32[7]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000}; // Inf-Inf
    v32[8]  = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0010}; // underflow
    v32[9]  = '{32'h00400000, 32'h00000000, 1'b0, 32'h00000000, 4'b0000}; // subnormal flush
    v32[10] = '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000}; // +0 + -0
    v32[11] = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000}; // NaN in
    v32[12] = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000}; // Inf + 1
    v32[13] = '{32'h3F800000, 32'hFF800000, 1'b1, 32'h7F800000, 4'b0000}; // 1 - (-Inf)
    v32[14] = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000}; // 3-1
    v32[15] = '{32'h3F800000, 32'h40400000, 1'b1, 32'hC0000000, 4'b0000}; // 1-3
    v32[16] = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000}; // 1+1
    v32[17] = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0001}; // above half -> up
    v32[18] = '{32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'b0001}; // sticky only
    v32[19] = '{32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 4'b0000}; // 1-2^-24 exact
    v32[20] = '{32'hC0000000, 32'hC0400000, 1'b0, 32'hC0A00000, 4'b0000}; // -2 + -3
    v16[0]  = '{32'h3C00, 32'h4000, 1'b0, 32'h4200, 4'b0000};
    v16[1]  = '{32'h7BFF, 32'h7BFF, 1'b0, 32'h7C00, 4'b0101};
    v16[2]  = '{32'h7C00, 32'h7C00, 1'b1, 32'h7E00, 4'b1000};

    reset_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; op_sub = 1'b0; in_tag = '0; out_ready = 1'b1;
    h_in_valid = 1'b0; h_a = '0; h_b = '0; h_op_sub = 1'b0; h_in_tag = '0; h_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst out_valid", 0, 32'(out_valid), 32'd0);
    chk("rst c", 0, c, 32'd0);
    chk("rst flags", 0, 32'(flags), 32'd0);
    chk("rst out_tag", 0, 32'(out_tag), 32'd0);
    chk("rst in_ready", 0, 32'(in_ready), 32'd1);

    for (int i = 0; i < 21; i++)
      run_op(1'b0, v32[i].a, v32[i].b, v32[i].op, 4'(i), v32[i].c, v32[i].f, i);
    for (int i = 0; i < 3; i++)
      run_op(1'b1, v16[i].a, v16[i].b, v16[i].op, 4'(i + 5), v16[i].c, v16[i].f, 100 + i);

    // Back-to-back stream of 20 with random downstream backpressure.
    sent = 0; rcvd = 0;
    for (int cyc = 0; cyc < 400 && rcvd < 20; cyc++) begin
      @(negedge clk);
      in_valid  = (sent < 20);
      a         = s_in(sent);
      b         = s_in(sent);
      op_sub    = 1'b0;
      in_tag    = sent[3:0];
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (out_valid && out_ready) begin
        chk("stream c", rcvd, c, s_out(rcvd));
        chk("stream tag", rcvd, 32'(out_tag), 32'(rcvd[3:0]));
        chk("stream flags", rcvd, 32'(flags), 32'd0);
        rcvd++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream count", 0, 32'(rcvd), 32'd20);
    extra = 0;
    repeat (8) begin
      @(negedge clk); #1;
      if (out_valid) extra++;
    end
    chk("stream extra", 0, 32'(extra), 32'd0);

    // Stalled downstream: pipeline holds exactly five ops, output stays stable.
    out_ready = 1'b0; acc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = 1'b1; a = s_in(acc); b = s_in(acc); op_sub = 1'b0; in_tag = 4'(acc);
      #1;
      if (in_ready) acc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("stall capacity", 0, 32'(acc), 32'd5);
    chk("stall in_ready", 0, 32'(in_ready), 32'd0);
    chk("stall held c", 0, c, s_out(0));
    chk("stall held valid", 0, 32'(out_valid), 32'd1);
    out_ready = 1'b1; rcvd = 0;
    for (int cyc = 0; cyc < 30 && rcvd < 5; cyc++) begin
      if (out_valid) begin
        chk("drain c", rcvd, c, s_out(rcvd));
        chk("drain tag", rcvd, 32'(out_tag), 32'(rcvd));
        rcvd++;
      end
      @(negedge clk); #1;
    end
    chk("drain count", 0, 32'(rcvd), 32'd5);

    // Reset while results are in flight and one is waiting at the output.
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; a = s_in(k); b = s_in(k); in_tag = 4'(k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    wcyc = 0;
    while (!out_valid && wcyc < 10) begin
      @(negedge clk);
      wcyc++;
    end
    chk("pre-reset valid", 0, 32'(out_valid), 32'd1);
    #3 reset_n = 1'b0;
    #1;
    chk("in-reset out_valid", 0, 32'(out_valid), 32'd0);
    chk("in-reset c", 0, c, 32'd0);
    chk("in-reset flags", 0, 32'(flags), 32'd0);
    chk("in-reset out_tag", 0, 32'(out_tag), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post-reset in_ready", 0, 32'(in_ready), 32'd1);
    out_ready = 1'b1; ghost = 0;
    repeat (10) begin
      @(negedge clk); #1;
      if (out_valid || h_out_valid) ghost++;
    end
    chk("post-reset ghosts", 0, 32'(ghost), 32'd0);
    run_op(1'b0, v32[0].a, v32[0].b, v32[0].op, 4'hA, v32[0].c, v32[0].f, 200);
    run_op(1'b1, v16[0].a, v16[0].b, v16[0].op, 4'hB, v16[0].c, v16[0].f, 201);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
